// File: rtl/player_input_if.sv
// Player-side signal bundle: raw button and switches in, game state and score pulses out.
// The game logic sits on the slave side; the stimulus or pattern source sits on the master side.
interface player_input_if;
    logic        key_n;
    logic [9:0]  sw;
    logic [9:0]  target;
    logic [1:0]  state;
    logic [11:0] combo;
    logic        hit;
    logic        miss;

    modport master (
        output key_n, sw, target,
        input  state, combo, hit, miss
    );

    modport slave (
        input  key_n, sw, target,
        output state, combo, hit, miss
    );
endinterface

// File: rtl/player_input.sv
// Reaction game front end. It synchronizes the button and the switches, debounces the button,
// and runs the IDLE/PLAY/STOP game with a combo counter, hit/miss pulses and a PLAY timeout.
module player_input #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
    input  logic          clk,
    input  logic          rst,
    player_input_if.slave pif
);

    localparam int unsigned SW_W    = 10;
    localparam int unsigned COMBO_W = 12;
    localparam int unsigned DCW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int unsigned TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [DCW-1:0]     DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]      TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_STOP = 2'd2
    } state_t;

    logic [1:0]      key_sync;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_s;
    logic            key_s;

    logic [1:0]      sync_vld;
    logic            armed;
    logic            deb;
    logic            deb_prev;
    logic [DCW-1:0]  db_cnt;
    logic            press_c;

    state_t             state_q, state_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    // Two-flop synchronizers; the key idles released, the switches idle low.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync <= 2'b11;
            sw_meta  <= '0;
            sw_s     <= '0;
        end else begin
            key_sync <= {key_sync[0], pif.key_n};
            sw_meta  <= pif.sw;
            sw_s     <= sw_meta;
        end
    end

    assign key_s = key_sync[1];

    // A key held through reset must be seen released before it may fire again. sync_vld
    // marks when key_s stops showing the reset value and starts reflecting the real pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & key_s);
        end
    end

    // Debounce: the level follows key_s only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb      <= 1'b1;
            deb_prev <= 1'b1;
            db_cnt   <= '0;
        end else begin
            deb_prev <= deb;
            if (key_s == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                deb    <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DCW'(1);
            end
        end
    end

    assign press_c = armed & deb_prev & ~deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            combo_q <= '0;
            timer_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            combo_q <= combo_d;
            timer_q <= timer_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // Game FSM. A press wins over a timer expiry that lands in the same cycle.
    always_comb begin
        state_d = state_q;
        combo_d = combo_q;
        timer_d = timer_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (press_c) begin
                    state_d = S_PLAY;
                    combo_d = '0;
                end
            end
            S_PLAY: begin
                if (press_c) begin
                    timer_d = '0;
                    if (sw_s == pif.target) begin
                        hit_d = 1'b1;
                        if (combo_q != COMBO_MAX) begin
                            combo_d = combo_q + COMBO_W'(1);
                        end
                    end else begin
                        state_d = S_STOP;
                        miss_d  = 1'b1;
                    end
                end else if (timer_q == TO_LAST) begin
                    state_d = S_STOP;
                    miss_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                timer_d = '0;
                if (press_c) begin
                    state_d = S_IDLE;
                    combo_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                combo_d = '0;
                timer_d = '0;
            end
        endcase
    end

    assign pif.state = state_q;
    assign pif.combo = combo_q;
    assign pif.hit   = hit_q;
    assign pif.miss  = miss_q;

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with a short debounce (4) and a short timeout (20).
// A negedge monitor counts hit and miss pulses; all checks go through one task.
module tb_player_input;

    logic clk;
    logic rst;

    player_input_if pif ();

    player_input #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned hit_cnt;
    int unsigned miss_cnt;
    int unsigned both_cnt;
    int unsigned long_cnt;
    logic        hit_prev;
    logic        miss_prev;

    // Pulse bookkeeping, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pif.hit) hit_cnt++;
            if (pif.miss) miss_cnt++;
            if (pif.hit && pif.miss) both_cnt++;
            if ((pif.hit && hit_prev) || (pif.miss && miss_prev)) long_cnt++;
        end
        hit_prev  = pif.hit;
        miss_prev = pif.miss;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release for 8 cycles, then press and keep holding for 8 cycles.
    task automatic press();
        pif.key_n = 1'b1;
        cycles(8);
        pif.key_n = 1'b0;
        cycles(8);
    endtask

    // Release, press, and return on the first negedge that shows PLAY.
    task automatic enter_play(input string tag);
        bit got;
        got = 1'b0;
        pif.key_n = 1'b1;
        cycles(8);
        pif.key_n = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pif.state == 2'd1) got = 1'b1;
        end
        check(tag, 32'(got), 1);
    endtask

    int unsigned h0;
    int unsigned m0;

    initial begin
        n_cmp = 0; n_bad = 0;
        hit_cnt = 0; miss_cnt = 0; both_cnt = 0; long_cnt = 0;
        hit_prev = 1'b0; miss_prev = 1'b0;
        rst = 1'b1;
        pif.key_n  = 1'b1;
        pif.sw     = 10'h000;
        pif.target = 10'h000;
        cycles(3);
        check("rst_state", 32'(pif.state), 0);
        check("rst_combo", 32'(pif.combo), 0);
        check("rst_hit",   32'(pif.hit),   0);
        check("rst_miss",  32'(pif.miss),  0);
        rst = 1'b0;
        cycles(6);

        // Short glitches never reach the debounced level.
        for (int i = 0; i < 5; i++) begin
            pif.key_n = 1'b0;
            cycles(2);
            pif.key_n = 1'b1;
            cycles(3);
        end
        cycles(4);
        check("glitch_state", 32'(pif.state), 0);
        check("glitch_pulses", hit_cnt + miss_cnt, 0);

        // Clean press from IDLE.
        pif.key_n = 1'b0;
        cycles(10);
        check("start_state", 32'(pif.state), 1);
        check("start_combo", 32'(pif.combo), 0);
        check("start_pulses", hit_cnt + miss_cnt, 0);

        // Three correct answers, then a wrong one.
        pif.target = 10'h2A5;
        pif.sw     = 10'h2A5;
        for (int i = 1; i <= 3; i++) begin
            h0 = hit_cnt;
            press();
            check("hit_state", 32'(pif.state), 1);
            check("hit_combo", 32'(pif.combo), 32'(i));
            check("hit_pulse", hit_cnt - h0, 1);
        end
        pif.sw = 10'h000;
        h0 = hit_cnt; m0 = miss_cnt;
        press();
        check("wrong_state", 32'(pif.state), 2);
        check("wrong_combo", 32'(pif.combo), 3);
        check("wrong_miss", miss_cnt - m0, 1);
        check("wrong_hit", hit_cnt - h0, 0);

        // STOP holds with the key held down; then a press returns to IDLE.
        cycles(30);
        check("stop_hold_state", 32'(pif.state), 2);
        check("stop_hold_combo", 32'(pif.combo), 3);
        h0 = hit_cnt; m0 = miss_cnt;
        press();
        check("stop_idle_state", 32'(pif.state), 0);
        check("stop_idle_combo", 32'(pif.combo), 0);
        check("stop_idle_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);

        // Timeout: 20 cycles in PLAY without a press.
        enter_play("to_entry");
        m0 = miss_cnt;
        cycles(19);
        check("to_before_state", 32'(pif.state), 1);
        check("to_before_miss", miss_cnt - m0, 0);
        cycles(1);
        check("to_state", 32'(pif.state), 2);
        check("to_miss_now", 32'(pif.miss), 1);
        check("to_combo", 32'(pif.combo), 0);
        cycles(1);
        check("to_miss_gone", 32'(pif.miss), 0);
        press();
        check("to_idle_state", 32'(pif.state), 0);
        check("to_idle_combo", 32'(pif.combo), 0);

        // Combo saturation.
        pif.sw = 10'h2A5;
        enter_play("sat_entry");
        force dut.combo_q = 12'hFFF;
        @(posedge clk);
        #1 release dut.combo_q;
        @(negedge clk);
        check("sat_forced", 32'(pif.combo), 4095);
        h0 = hit_cnt;
        press();
        check("sat_combo", 32'(pif.combo), 4095);
        check("sat_hit", hit_cnt - h0, 1);
        check("sat_state", 32'(pif.state), 1);

        // Reset in PLAY with combo 5 and the key held.
        pif.sw = 10'h000;
        press();
        check("r_stop", 32'(pif.state), 2);
        press();
        check("r_idle", 32'(pif.state), 0);
        pif.sw = 10'h2A5;
        enter_play("r_entry");
        for (int i = 0; i < 5; i++) press();
        check("r_combo5", 32'(pif.combo), 5);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("r_state", 32'(pif.state), 0);
        check("r_combo", 32'(pif.combo), 0);
        h0 = hit_cnt; m0 = miss_cnt;
        cycles(20);
        check("r_held_state", 32'(pif.state), 0);
        check("r_held_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);
        press();
        check("r_repress_state", 32'(pif.state), 1);
        check("r_repress_combo", 32'(pif.combo), 0);

        check("never_both", both_cnt, 0);
        check("single_cycle_pulses", long_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
